arbiter_rr_6x1_64bit: RTL

- Round-robin arbiter and output stage that shares one 64-bit 6:1 selection path between six requesters (sources A..F, indices 0..5).
- Chooses a winner each time its output register can accept data and drives the matching select code.
- Captures the selected word into a registered output with a valid/ready handshake.
- Sits in front of any shared 64-bit consumer (register-file write port, memory write bus) that several datapath units contend for.

---
 rtl/arbiter_rr_6x1_64bit.sv | 112 +++++++++++
 1 files changed

// File: rtl/arbiter_rr_6x1_64bit.sv
// Round-robin 6:1 arbiter with a registered WIDTH-bit output stage (X, S, out_valid).
// Latency: a word granted at a rising edge appears on X/S after that same edge (1 cycle).
// Backpressure: while out_valid=1 and out_ready=0 nothing is granted and X/S/out_valid hold.
module arbiter_rr_6x1_64bit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    output logic [5:0]       grant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X,
    output logic [2:0]       S,
    output logic             busy
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [2:0]       s_q, s_d;

    logic [2:0]       win_idx;
    logic             win_found;
    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] sel_dat;

    // Search from the source after the last winner, wrapping, and take the first requester.
    always_comb begin
        win_idx   = 3'd0;
        win_found = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            logic [2:0] idx;
            idx = 3'((int'(ptr_q) + k) % 6);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // 6:1 data mux driven by the winning index.
    always_comb begin
        sel_dat = '0;
        case (win_idx)
            3'd0:    sel_dat = A;
            3'd1:    sel_dat = B;
            3'd2:    sel_dat = C;
            3'd3:    sel_dat = D;
            3'd4:    sel_dat = E;
            3'd5:    sel_dat = F;
            default: sel_dat = '0;
        endcase
    end

    // Next-state logic: capture when the output register is free or being drained.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        x_d     = x_q;
        s_d     = s_q;
        grant   = 6'b000000;

        accept  = (state_q == ST_EMPTY) || out_ready;
        // Reset suppresses the grant so no requester sees a phantom transfer.
        capture = accept && win_found && !reset;

        if (capture) begin
            grant   = 6'b000001 << win_idx;
            state_d = ST_FULL;
            x_d     = sel_dat;
            s_d     = win_idx;
            ptr_d   = win_idx;
        end else if (state_q == ST_FULL && out_ready) begin
            // Drained with nothing new: X/S keep stale values, qualified by out_valid.
            state_d = ST_EMPTY;
        end
    end

    // State registers; ptr resets to 5 so source 0 has first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            ptr_q   <= 3'd5;
            x_q     <= '0;
            s_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            x_q     <= x_d;
            s_q     <= s_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign busy      = out_valid;
    assign X         = x_q;
    assign S         = s_q;

endmodule
